pifo_push_arbiter: RTL and testbench

//  Shares the single push port of a PIFO wrapper between NUM_REQ descriptor producers.

---
 rtl/pifo_push_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_pifo_push_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_push_arbiter.sv
// pifo_push_arbiter: shares one PIFO push port between NUM_REQ producers.
// Round-robin grant into a one-entry output register, PIFO occupancy tracking
// from push/pop/drop events with full backpressure, and watermark-forced drop hint.
// Build option: define PIFO_ARB_STATS_EN to add per-requester transfer counters
// readable through stat_sel/stat_cnt; otherwise stat_cnt is tied to zero.
module pifo_push_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned BITPRIO  = 16,
  parameter int unsigned BITDESC  = 32,
  parameter int unsigned CAPACITY = 1024,
  parameter int unsigned DROP_WM  = 1020,
  parameter int unsigned MIN_OCC  = 8,
  localparam int unsigned SrcW    = $clog2(NUM_REQ),
  localparam int unsigned OccW    = $clog2(CAPACITY) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         s_valid,
  output logic [NUM_REQ-1:0]         s_ready,
  input  logic [NUM_REQ*BITPRIO-1:0] s_prio,
  input  logic [NUM_REQ*BITDESC-1:0] s_data,
  input  logic [NUM_REQ-1:0]         s_drop,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BITPRIO-1:0]         m_prio,
  output logic [BITDESC-1:0]         m_data,
  output logic                       m_drop,
  output logic [SrcW-1:0]            m_src,
  input  logic                       pop_done,
  input  logic                       drop_done,
  output logic [OccW-1:0]            occ,
  output logic                       occ_err,
  input  logic [SrcW-1:0]            stat_sel,
  output logic [31:0]                stat_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic [SrcW-1:0]    rr_ptr_q;
  logic               grant_en_q;
  logic [OccW-1:0]    occ_q, occ_d;
  logic               occ_err_q, occ_err_d;
  logic [BITPRIO-1:0] m_prio_q;
  logic [BITDESC-1:0] m_data_q;
  logic               m_drop_q;
  logic [SrcW-1:0]    m_src_q;

  logic               blk;
  logic               ld;
  logic               grant_vld;
  logic [SrcW-1:0]    grant_idx;
  logic [SrcW:0]      cand_w;
  logic               force_drop;
  logic [OccW:0]      occ_up;
  logic [1:0]         occ_dn;

  logic [BITPRIO-1:0] prio_arr [NUM_REQ];
  logic [BITDESC-1:0] data_arr [NUM_REQ];

  // Unpack the flat request buses into per-requester views.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign prio_arr[i] = s_prio[i*BITPRIO +: BITPRIO];
    assign data_arr[i] = s_data[i*BITDESC +: BITDESC];
  end

  // The held entry counts against capacity, so stop granting once it would fill the PIFO.
  assign blk = ((32'(occ_q) + 32'(m_valid)) == CAPACITY);
  assign ld  = ((state_q == StEmpty) || m_ready) && !blk;

  assign force_drop = (32'(occ_q) >= DROP_WM) && (32'(occ_q) > MIN_OCC);

  // Round-robin search from rr_ptr_q; independent of any handshake response.
  always_comb begin
    s_ready   = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_w    = '0;
    if (ld && grant_en_q) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_w = {1'b0, rr_ptr_q} + (SrcW+1)'(k);
        if (cand_w >= (SrcW+1)'(NUM_REQ)) begin
          cand_w = cand_w - (SrcW+1)'(NUM_REQ);
        end
        if (!grant_vld && s_valid[cand_w[SrcW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand_w[SrcW-1:0];
        end
      end
    end
    if (grant_vld) begin
      s_ready[grant_idx] = 1'b1;
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage next state: a transfer always (re)fills, a drain without refill empties.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant_vld) state_d = StFull;
      StFull: begin
        if (grant_vld) begin
          state_d = StFull;
        end else if (m_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output-stage outputs.
  always_comb begin
    m_valid = (state_q == StFull);
  end

  // Grant enable stays low through reset so the first grant follows the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_en_q <= 1'b0;
    end else begin
      grant_en_q <= 1'b1;
    end
  end

  // Round-robin pointer moves past the winner on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (grant_vld) begin
      if (32'(grant_idx) == NUM_REQ - 1) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= grant_idx + SrcW'(1);
      end
    end
  end

  // Entry register loads the winner's fields; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prio_q <= '0;
      m_data_q <= '0;
      m_drop_q <= 1'b0;
      m_src_q  <= '0;
    end else if (grant_vld) begin
      m_prio_q <= prio_arr[grant_idx];
      m_data_q <= data_arr[grant_idx];
      m_drop_q <= s_drop[grant_idx] | force_drop;
      m_src_q  <= grant_idx;
    end
  end

  // Net occupancy update; underflow clamps to zero and latches the error.
  always_comb begin
    occ_err_d = occ_err_q;
    occ_up    = {1'b0, occ_q} + (OccW+1)'(m_valid & m_ready);
    occ_dn    = {1'b0, pop_done} + {1'b0, drop_done};
    if (occ_up < (OccW+1)'(occ_dn)) begin
      occ_d     = '0;
      occ_err_d = 1'b1;
    end else begin
      occ_d = OccW'(occ_up - (OccW+1)'(occ_dn));
    end
  end

  // Occupancy and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= '0;
      occ_err_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      occ_err_q <= occ_err_d;
    end
  end

  assign m_prio  = m_prio_q;
  assign m_data  = m_data_q;
  assign m_drop  = m_drop_q;
  assign m_src   = m_src_q;
  assign occ     = occ_q;
  assign occ_err = occ_err_q;

`ifdef PIFO_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];
  logic [31:0] stat_q;

  // Per-requester transfer counters (wrap naturally) and registered readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      stat_q <= '0;
    end else begin
      if (grant_vld) begin
        cnt_q[grant_idx] <= cnt_q[grant_idx] + 32'd1;
      end
      stat_q <= cnt_q[stat_sel];
    end
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_pifo_push_arbiter.sv
// Bench for pifo_push_arbiter: two instances share stimulus (different drop
// watermarks), compared each cycle against a transaction-level reference model.
module tb_pifo_push_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned BP    = 16;
  localparam int unsigned BD    = 32;
  localparam int unsigned CAP   = 16;
  localparam int unsigned SW    = $clog2(N);
  localparam int unsigned OW    = $clog2(CAP) + 1;
  localparam int          WM_A  = 12;
  localparam int          MIN_A = 4;
  localparam int          WM_B  = 4;
  localparam int          MIN_B = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      s_valid;
  logic [N*BP-1:0]   s_prio;
  logic [N*BD-1:0]   s_data;
  logic [N-1:0]      s_drop;
  logic              m_ready;
  logic              pop_done;
  logic              drop_done;
  logic [SW-1:0]     stat_sel;

  logic [N-1:0]      s_ready_a, s_ready_b;
  logic              m_valid_a, m_valid_b;
  logic [BP-1:0]     m_prio_a, m_prio_b;
  logic [BD-1:0]     m_data_a, m_data_b;
  logic              m_drop_a, m_drop_b;
  logic [SW-1:0]     m_src_a, m_src_b;
  logic [OW-1:0]     occ_a, occ_b;
  logic              occ_err_a, occ_err_b;
  logic [31:0]       stat_a, stat_b;

  always #5 clk = ~clk;

  pifo_push_arbiter #(
    .NUM_REQ(N), .BITPRIO(BP), .BITDESC(BD), .CAPACITY(CAP), .DROP_WM(WM_A), .MIN_OCC(MIN_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_prio(s_prio),
    .s_data(s_data), .s_drop(s_drop), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_prio(m_prio_a), .m_data(m_data_a), .m_drop(m_drop_a), .m_src(m_src_a),
    .pop_done(pop_done), .drop_done(drop_done), .occ(occ_a), .occ_err(occ_err_a),
    .stat_sel(stat_sel), .stat_cnt(stat_a)
  );

  pifo_push_arbiter #(
    .NUM_REQ(N), .BITPRIO(BP), .BITDESC(BD), .CAPACITY(CAP), .DROP_WM(WM_B), .MIN_OCC(MIN_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_prio(s_prio),
    .s_data(s_data), .s_drop(s_drop), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_prio(m_prio_b), .m_data(m_data_b), .m_drop(m_drop_b), .m_src(m_src_b),
    .pop_done(pop_done), .drop_done(drop_done), .occ(occ_b), .occ_err(occ_err_b),
    .stat_sel(stat_sel), .stat_cnt(stat_b)
  );

  int checks = 0;
  int failures = 0;
  int grants_seen = 0;

  // Reference model state
  int          occ_m, ptr_m;
  bit          err_m, mv_m, mdrop_a_m, mdrop_b_m;
  logic [BP-1:0] mprio_m;
  logic [BD-1:0] mdata_m;
  int          msrc_m;
  int unsigned cnt_m [N];
  int unsigned stat_m;
  logic        pp_r, dd_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ_m = 0; ptr_m = 0; err_m = 0; mv_m = 0;
    mdrop_a_m = 0; mdrop_b_m = 0; mprio_m = '0; mdata_m = '0; msrc_m = 0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    stat_m = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic mr, input logic pp, input logic dd,
                       input logic [N-1:0] sd);
    s_valid = v; m_ready = mr; pop_done = pp; drop_done = dd; s_drop = sd;
    for (int i = 0; i < N; i++) begin
      s_prio[i*BP +: BP] = BP'($urandom);
      s_data[i*BD +: BD] = $urandom;
    end
    stat_sel = SW'($urandom_range(0, N - 1));
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle();
    int g;
    int nocc;
    bit ld;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    ld = (!mv_m || m_ready) && (occ_m + int'(mv_m) != CAP);
    if (ld) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && s_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (s_ready_a != '0) grants_seen++;
    chk("s_ready_a", s_ready_a, exp_rdy);
    chk("s_ready_b", s_ready_b, exp_rdy);
    chk("m_valid_a", m_valid_a, mv_m);
    chk("m_valid_b", m_valid_b, mv_m);
    chk("occ_a", occ_a, occ_m);
    chk("occ_b", occ_b, occ_m);
    chk("occ_err_a", occ_err_a, err_m);
`ifdef PIFO_ARB_STATS_EN
    chk("stat_cnt", stat_a, stat_m);
`else
    chk("stat_cnt", stat_a, 0);
`endif
    if (mv_m) begin
      chk("m_prio", m_prio_a, mprio_m);
      chk("m_data", m_data_a, mdata_m);
      chk("m_src", m_src_a, msrc_m);
      chk("m_drop_a", m_drop_a, mdrop_a_m);
      chk("m_drop_b", m_drop_b, mdrop_b_m);
    end
    @(posedge clk);
    nocc = occ_m + ((mv_m && m_ready) ? 1 : 0) - int'(pop_done) - int'(drop_done);
    if (nocc < 0) begin
      nocc = 0;
      err_m = 1;
    end
    stat_m = cnt_m[stat_sel];
    if (g >= 0) begin
      mprio_m   = s_prio[g*BP +: BP];
      mdata_m   = s_data[g*BD +: BD];
      msrc_m    = g;
      mdrop_a_m = s_drop[g] | (occ_m >= WM_A && occ_m > MIN_A);
      mdrop_b_m = s_drop[g] | (occ_m >= WM_B && occ_m > MIN_B);
      ptr_m     = (g + 1) % N;
      mv_m      = 1;
      cnt_m[g]  = cnt_m[g] + 1;
    end else if (m_ready) begin
      mv_m = 0;
    end
    occ_m = nocc;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && (occ_m != 0 || mv_m); k++) begin
      drive('0, 1'b1, occ_m > 0, 1'b0, '0);
      cycle();
    end
    chk("drain_occ", occ_a, 0);
    chk("drain_mvalid", m_valid_a, 0);
  endtask

  initial begin
    int g0;
    model_reset();
    rst_n = 1'b0;
    drive('1, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_prio", m_prio_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_m_drop", m_drop_a, 0);
    chk("rst_m_src", m_src_a, 0);
    chk("rst_occ", occ_a, 0);
    chk("rst_occ_err", occ_err_a, 0);
    chk("rst_stat", stat_a, 0);
    rst_n = 1'b1;
    drive('0, 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;

    // T1: all requesters valid, round-robin order one per cycle
    for (int i = 0; i < 12; i++) begin
      drive('1, 1'b1, occ_m > 0, 1'b0, N'($urandom));
      cycle();
      chk("t1_src_seq", m_src_a, i % N);
      chk("t1_valid", m_valid_a, 1);
    end
    drain();

    // T2: single requester, fixed payload
    drive(4'b0100, 1'b1, 1'b0, 1'b0, '0);
    s_prio[2*BP +: BP] = 16'h0010;
    s_data[2*BD +: BD] = 32'hDEAD_BEEF;
    cycle();
    chk("t2_valid", m_valid_a, 1);
    chk("t2_prio", m_prio_a, 16'h0010);
    chk("t2_data", m_data_a, 32'hDEAD_BEEF);
    chk("t2_src", m_src_a, 2);

    // T3: stall with all valid, then release
    drive('1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_no_grant", s_ready_a, 0);
      chk("t3_data_hold", m_data_a, 32'hDEAD_BEEF);
      chk("t3_prio_hold", m_prio_a, 16'h0010);
    end
    drive('1, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    chk("t3_next_src", m_src_a, 3);
    chk("t3_next_valid", m_valid_a, 1);
    chk("t3_occ", occ_a, 1);
    drain();

    // T4: fill to capacity with no pops
    drive('1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 25; i++) cycle();
    chk("t4_occ_full", occ_a, CAP);
    chk("t4_blocked", s_ready_a, 0);
    chk("t4_empty_out", m_valid_a, 0);
    g0 = grants_seen;
    drive('1, 1'b1, 1'b1, 1'b0, '0);
    cycle();
    drive('1, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle();
    chk("t4_one_grant", grants_seen - g0, 1);
    chk("t4_occ_refull", occ_a, CAP);
    chk("t4_forced_drop", m_drop_a, 1);

    // T5: drop hint around the watermarks
    for (int k = 0; k < 16 && occ_m > 8; k++) begin
      drive('0, 1'b1, 1'b1, 1'b0, '0);
      cycle();
    end
    chk("t5_occ8", occ_a, 8);
    drive(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    cycle();
    chk("t5_b_minocc_nodrop", m_drop_b, 0);
    chk("t5_a_low_nodrop", m_drop_a, 0);
    drive(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010);
    cycle();
    chk("t5_b_minocc_sdrop", m_drop_b, 1);
    chk("t5_a_sdrop", m_drop_a, 1);
    drive(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 10 && occ_m != 11; k++) cycle();
    cycle();
    chk("t5_a_below_wm", m_drop_a, 0);
    chk("t5_b_above_min", m_drop_b, 1);
    cycle();
    chk("t5_a_at_wm", m_drop_a, 1);
    drain();

    // Randomized traffic with legal pop/drop events
    for (int n = 0; n < 300; n++) begin
      pp_r = ($urandom_range(0, 1) == 1) && (occ_m >= 1);
      dd_r = ($urandom_range(0, 3) == 0) && (occ_m >= (pp_r ? 2 : 1));
      drive(N'($urandom), $urandom_range(0, 3) != 0, pp_r, dd_r, N'($urandom));
      cycle();
    end
    drain();

    // T6: underflow and simultaneous events
    drive('0, 1'b1, 1'b1, 1'b0, '0);
    cycle();
    chk("t6_occ_clamp", occ_a, 0);
    chk("t6_err", occ_err_a, 1);
    drive(4'b0001, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 20 && occ_m != 5; k++) cycle();
    chk("t6_occ5", occ_a, 5);
    drive('0, 1'b1, 1'b1, 1'b1, '0);
    cycle();
    chk("t6_net_update", occ_a, 4);
    chk("t6_err_sticky", occ_err_a, 1);

    // Reset while holding an entry
    drive('1, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", m_valid_a, 0);
    chk("mid_rst_ready", s_ready_a, 0);
    chk("mid_rst_occ", occ_a, 0);
    chk("mid_rst_err", occ_err_a, 0);
    chk("mid_rst_data", m_data_a, 0);
    drive('0, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 20; n++) begin
      drive(N'($urandom), 1'b1, occ_m > 0, 1'b0, N'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
